// File: rtl/mem_arbiter_if.sv
// Bundles the CPU fetch/load-store request ports and the MMU command port of mem_arbiter.
// The master side is the CPU plus the MMU read-data source; the slave side is the arbiter.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_byte;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        mmu_read;
  logic        mmu_write;
  logic [31:0] mmu_addr;
  logic [31:0] mmu_wdata;
  logic        mmu_bytemode;
  logic [31:0] mmu_rdata;

  logic        stall;

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_byte, mmu_rdata,
    input  if_rdata, if_ack, mem_rdata, mem_ack,
    input  mmu_read, mmu_write, mmu_addr, mmu_wdata, mmu_bytemode, stall
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_byte, mmu_rdata,
    output if_rdata, if_ack, mem_rdata, mem_ack,
    output mmu_read, mmu_write, mmu_addr, mmu_wdata, mmu_bytemode, stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store requests onto one MMU port; ack comes WAIT_CYCLES+1 cycles after the
// request is sampled, one access per WAIT_CYCLES+2 cycles; the losing/waiting port sees stall until its ack.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        grant_mem, grant_mem_nxt;
  logic        last_mem, last_mem_nxt;
  logic [31:0] cmd_addr, cmd_addr_nxt;
  logic [31:0] cmd_wdata, cmd_wdata_nxt;
  logic        cmd_we, cmd_we_nxt;
  logic        cmd_byte, cmd_byte_nxt;
  logic [31:0] if_rdata_q, if_rdata_nxt;
  logic [31:0] mem_rdata_q, mem_rdata_nxt;
  logic        pick_mem;

  // MEM wins by default; IF wins when MEM had the previous grant, so neither port starves.
  assign pick_mem = bus.mem_req & ~(last_mem & bus.if_req);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    grant_mem_nxt = grant_mem;
    last_mem_nxt  = last_mem;
    cmd_addr_nxt  = cmd_addr;
    cmd_wdata_nxt = cmd_wdata;
    cmd_we_nxt    = cmd_we;
    cmd_byte_nxt  = cmd_byte;
    if_rdata_nxt  = if_rdata_q;
    mem_rdata_nxt = mem_rdata_q;
    case (state)
      IDLE: begin
        if (bus.if_req | bus.mem_req) begin
          grant_mem_nxt = pick_mem;
          last_mem_nxt  = pick_mem;
          cmd_addr_nxt  = pick_mem ? bus.mem_addr : bus.if_addr;
          cmd_wdata_nxt = pick_mem ? bus.mem_wdata : 32'h0;
          cmd_we_nxt    = pick_mem & bus.mem_we;
          cmd_byte_nxt  = pick_mem & bus.mem_byte;
          cnt_nxt       = CNT_INIT;
          state_nxt     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          if (!cmd_we) begin
            if (grant_mem) mem_rdata_nxt = bus.mmu_rdata;
            else           if_rdata_nxt  = bus.mmu_rdata;
          end
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      grant_mem   <= 1'b0;
      last_mem    <= 1'b0;
      cmd_addr    <= 32'h0;
      cmd_wdata   <= 32'h0;
      cmd_we      <= 1'b0;
      cmd_byte    <= 1'b0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      grant_mem   <= grant_mem_nxt;
      last_mem    <= last_mem_nxt;
      cmd_addr    <= cmd_addr_nxt;
      cmd_wdata   <= cmd_wdata_nxt;
      cmd_we      <= cmd_we_nxt;
      cmd_byte    <= cmd_byte_nxt;
      if_rdata_q  <= if_rdata_nxt;
      mem_rdata_q <= mem_rdata_nxt;
    end
  end

  // Strobes come straight from registers so the MMU sees a glitch-free, stable window.
  assign bus.mmu_read     = (state == ACCESS) & ~cmd_we;
  assign bus.mmu_write    = (state == ACCESS) & cmd_we;
  assign bus.mmu_addr     = cmd_addr;
  assign bus.mmu_wdata    = cmd_wdata;
  assign bus.mmu_bytemode = cmd_byte;

  assign bus.if_ack    = (state == DONE) & ~grant_mem;
  assign bus.mem_ack   = (state == DONE) & grant_mem;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;

  assign bus.stall = (bus.if_req & ~bus.if_ack) | (bus.mem_req & ~bus.mem_ack);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (WAIT_CYCLES 2 and 1) checked every cycle against a
// transaction-timeline model, plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;
  localparam int N = 2;

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_byte;
    logic [31:0] mmu_rdata;
  } stim_t;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bytemode;
    logic        if_ack;
    logic        mem_ack;
    logic [31:0] if_rdata;
    logic [31:0] mem_rdata;
    logic        stall;
  } obs_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  stim_t st [N];
  obs_t  ob [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : inst
    mem_arbiter_if bus ();
    assign bus.if_req    = st[g].if_req;
    assign bus.if_addr   = st[g].if_addr;
    assign bus.mem_req   = st[g].mem_req;
    assign bus.mem_we    = st[g].mem_we;
    assign bus.mem_addr  = st[g].mem_addr;
    assign bus.mem_wdata = st[g].mem_wdata;
    assign bus.mem_byte  = st[g].mem_byte;
    assign bus.mmu_rdata = st[g].mmu_rdata;
    assign ob[g] = {bus.mmu_read, bus.mmu_write, bus.mmu_addr, bus.mmu_wdata, bus.mmu_bytemode,
                    bus.if_ack, bus.mem_ack, bus.if_rdata, bus.mem_rdata, bus.stall};
    mem_arbiter #(.WAIT_CYCLES(g == 0 ? 2 : 1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  end

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Model: a transaction granted in cycle g is active in cycles g+1..g+W and acked in g+W+1.
  int        cyc;
  bit        busy      [N];
  int        gcyc      [N];
  bit        win_mem   [N];
  bit        last_mem  [N];
  bit [31:0] c_addr    [N];
  bit [31:0] c_wdata   [N];
  bit        c_we      [N];
  bit        c_byte    [N];
  bit [31:0] x_if_rd   [N];
  bit [31:0] x_mem_rd  [N];
  bit        seen_if_ack  [N];
  bit        seen_mem_ack [N];

  always @(negedge clk) begin
    obs_t e;
    int   w, off;
    bit   act, ack;
    for (int i = 0; i < N; i++) begin
      w   = (i == 0) ? 2 : 1;
      off = cyc - gcyc[i];
      act = busy[i] && off >= 1 && off <= w;
      ack = busy[i] && off == w + 1;
      e.read      = act & ~c_we[i];
      e.write     = act & c_we[i];
      e.addr      = c_addr[i];
      e.wdata     = c_wdata[i];
      e.bytemode  = c_byte[i];
      e.if_ack    = ack & ~win_mem[i];
      e.mem_ack   = ack & win_mem[i];
      e.if_rdata  = x_if_rd[i];
      e.mem_rdata = x_mem_rd[i];
      e.stall     = (st[i].if_req & ~e.if_ack) | (st[i].mem_req & ~e.mem_ack);
      chk($sformatf("i%0d.mmu_read", i),  ob[i].read,      e.read);
      chk($sformatf("i%0d.mmu_write", i), ob[i].write,     e.write);
      chk($sformatf("i%0d.mmu_addr", i),  ob[i].addr,      e.addr);
      chk($sformatf("i%0d.mmu_wdata", i), ob[i].wdata,     e.wdata);
      chk($sformatf("i%0d.mmu_byte", i),  ob[i].bytemode,  e.bytemode);
      chk($sformatf("i%0d.if_ack", i),    ob[i].if_ack,    e.if_ack);
      chk($sformatf("i%0d.mem_ack", i),   ob[i].mem_ack,   e.mem_ack);
      chk($sformatf("i%0d.if_rdata", i),  ob[i].if_rdata,  e.if_rdata);
      chk($sformatf("i%0d.mem_rdata", i), ob[i].mem_rdata, e.mem_rdata);
      chk($sformatf("i%0d.stall", i),     ob[i].stall,     e.stall);
      seen_if_ack[i]  = ob[i].if_ack;
      seen_mem_ack[i] = ob[i].mem_ack;

      if (rst) begin
        busy[i] = 0; last_mem[i] = 0; c_addr[i] = 0; c_wdata[i] = 0;
        c_we[i] = 0; c_byte[i] = 0; x_if_rd[i] = 0; x_mem_rd[i] = 0;
      end else if (busy[i]) begin
        if (off == w && !c_we[i]) begin
          if (win_mem[i]) x_mem_rd[i] = st[i].mmu_rdata;
          else            x_if_rd[i]  = st[i].mmu_rdata;
        end
        if (off == w + 1) busy[i] = 0;
      end else if (st[i].if_req || st[i].mem_req) begin
        win_mem[i]  = st[i].mem_req && !(last_mem[i] && st[i].if_req);
        last_mem[i] = win_mem[i];
        busy[i]     = 1;
        gcyc[i]     = cyc;
        c_addr[i]   = win_mem[i] ? st[i].mem_addr : st[i].if_addr;
        c_wdata[i]  = win_mem[i] ? st[i].mem_wdata : 32'h0;
        c_we[i]     = win_mem[i] & st[i].mem_we;
        c_byte[i]   = win_mem[i] & st[i].mem_byte;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] ord;
    int         nack;
    for (int i = 0; i < N; i++) st[i] = '0;
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    step();

    // Single fetch on the WAIT_CYCLES=2 instance
    st[0].if_req = 1; st[0].if_addr = 32'h8000_0010; st[0].mmu_rdata = 32'h1234_5678;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      chk("t1.read", ob[0].read, 32'(c == 1 || c == 2));
      chk("t1.ack", ob[0].if_ack, 32'(c == 3));
      if (c == 1) chk("t1.addr", ob[0].addr, 32'h8000_0010);
      if (c == 3) begin
        chk("t1.rdata", ob[0].if_rdata, 32'h1234_5678);
        chk("t1.byte", ob[0].bytemode, 32'h0);
        chk("t1.model_rdata", x_if_rd[0], 32'h1234_5678);
      end
      step();
      if (c == 3) st[0].if_req = 0;
    end

    // Byte store
    st[0].mem_req = 1; st[0].mem_we = 1; st[0].mem_byte = 1;
    st[0].mem_addr = 32'h8040_0004; st[0].mem_wdata = 32'h0000_00A5;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      chk("t2.write", ob[0].write, 32'(c == 1 || c == 2));
      chk("t2.ack", ob[0].mem_ack, 32'(c == 3));
      if (c == 2) begin
        chk("t2.byte", ob[0].bytemode, 32'h1);
        chk("t2.wdata", ob[0].wdata, 32'h0000_00A5);
        chk("t2.addr", ob[0].addr, 32'h8040_0004);
      end
      if (c == 3) chk("t2.rdata", ob[0].mem_rdata, 32'h0);
      step();
      if (c == 3) begin st[0].mem_req = 0; st[0].mem_we = 0; st[0].mem_byte = 0; end
    end

    // Both requests held from reset: MEM, IF, MEM, IF
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    st[0].if_req = 1; st[0].if_addr = 32'h0000_0100;
    st[0].mem_req = 1; st[0].mem_addr = 32'h0000_0200; st[0].mmu_rdata = 32'hDEAD_BEEF;
    ord = 4'h0; nack = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("t3.stall", ob[0].stall, 32'h1);
      chk("t3.ack", ob[0].if_ack | ob[0].mem_ack, 32'(c % 4 == 3));
      if (ob[0].if_ack | ob[0].mem_ack) begin
        ord = {ord[2:0], ob[0].mem_ack};
        nack++;
      end
      step();
    end
    st[0].if_req = 0; st[0].mem_req = 0;
    chk("t3.nack", nack, 32'd4);
    chk("t3.order", 32'(ord), 32'hA);

    // Load whose request drops during ACCESS
    step();
    st[0].mem_req = 1; st[0].mem_addr = 32'h8000_0040; st[0].mmu_rdata = 32'h0BAD_F00D;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      chk("t4.ack", ob[0].mem_ack, 32'(c == 3));
      chk("t4.read", ob[0].read | ob[0].write, 32'(c == 1 || c == 2));
      if (c == 3) chk("t4.rdata", ob[0].mem_rdata, 32'h0BAD_F00D);
      step();
      if (c == 0) st[0].mem_req = 0;
    end

    // Reset during the second ACCESS cycle, then a normal fetch
    st[0].if_req = 1; st[0].if_addr = 32'h8000_0080; st[0].mmu_rdata = 32'h1111_2222;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      chk("t5.read", ob[0].read, 32'(c == 1 || c == 2 || c == 6 || c == 7));
      chk("t5.ack", ob[0].if_ack, 32'(c == 8));
      if (c == 8) chk("t5.rdata", ob[0].if_rdata, 32'hCAFE_F00D);
      step();
      case (c)
        1: begin rst = 1; st[0].if_req = 0; end
        2: rst = 0;
        4: begin st[0].if_req = 1; st[0].if_addr = 32'h8000_0084; st[0].mmu_rdata = 32'hCAFE_F00D; end
        8: st[0].if_req = 0;
        default: ;
      endcase
    end

    // WAIT_CYCLES=1: alternating load/store to the UART address
    st[1].mem_req = 1; st[1].mem_we = 0; st[1].mem_addr = 32'hBFD0_03F8; st[1].mmu_rdata = 32'h0000_0041;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("t6.ack", ob[1].mem_ack, 32'(c % 3 == 2));
      chk("t6.active", ob[1].read | ob[1].write, 32'(c % 3 == 1));
      if (c % 3 == 1) begin
        chk("t6.addr", ob[1].addr, 32'hBFD0_03F8);
        chk("t6.write", ob[1].write, 32'((c / 3) % 2));
      end
      step();
      if (c % 3 == 2) begin
        st[1].mem_we = ~st[1].mem_we;
        st[1].mem_wdata = $urandom;
        st[1].mmu_rdata = $urandom;
      end
    end
    st[1].mem_req = 0;
    step();

    // Randomised traffic on both instances; the model checks every cycle
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(399) == 0);
      for (int i = 0; i < N; i++) begin
        st[i].mmu_rdata = $urandom;
        if (st[i].if_req) begin
          if (seen_if_ack[i] ? ($urandom_range(3) != 0) : ($urandom_range(31) == 0)) st[i].if_req = 0;
        end else if ($urandom_range(2) == 0) begin
          st[i].if_req = 1; st[i].if_addr = $urandom;
        end
        if (st[i].mem_req) begin
          if (seen_mem_ack[i] ? ($urandom_range(3) != 0) : ($urandom_range(31) == 0)) st[i].mem_req = 0;
        end else if ($urandom_range(2) == 0) begin
          st[i].mem_req = 1; st[i].mem_we = 1'($urandom); st[i].mem_byte = 1'($urandom);
          st[i].mem_addr = $urandom; st[i].mem_wdata = $urandom;
        end
      end
      step();
    end
    rst = 0;
    for (int i = 0; i < N; i++) begin st[i].if_req = 0; st[i].mem_req = 0; end
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer between the CPU core and the MMU. It takes requests from the instruction-fetch port and the load/store port and serialises them onto the MMU's single read/write interface. Each access has a fixed, parameterised hold time, during which the MMU command is held stable, so SRAM/UART strobes see a clean window. It returns read data and a one-cycle acknowledge to the granted requester, and produces a pipeline stall signal.

## Interface
- WAIT_CYCLES, 2, cycles an MMU command is held before data is captured; legal range 1..15
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetch data; valid in the if_ack cycle, held until the next fetch capture
- if_ack  out  1  one-cycle completion pulse
- mem_req  in  1  load/store request; held until mem_ack
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  32  load/store byte address
- mem_wdata  in  32  store data
- mem_byte  in  1  byte-mode access
- mem_rdata  out  32  load data; valid in the mem_ack cycle, held until the next load capture
- mem_ack  out  1  one-cycle completion pulse
- mmu_read  out  1  MMU read enable
- mmu_write  out  1  MMU write enable
- mmu_addr  out  32  MMU address
- mmu_wdata  out  32  MMU write data
- mmu_bytemode  out  1  MMU byte mode
- mmu_rdata  in  32  MMU read data
- stall  out  1  (if_req & ~if_ack) | (mem_req & ~mem_ack), combinational

## Operation
- FSM states: IDLE, ACCESS, DONE. State register, wait counter (4 bits), grant register (IF/MEM), last_grant register.
- **IDLE**
  - Requests are sampled only in this state.
  - MEM is granted if mem_req=1, except when last_grant=MEM and if_req=1; then IF is granted. This alternates grants and prevents starvation.
  - On a grant, latch address, we, wdata and byte into command registers. Load counter = WAIT_CYCLES-1, set last_grant, go to ACCESS.
- **ACCESS**
  - mmu_read = ~cmd_we and mmu_write = cmd_we, driven from registers only.
  - mmu_addr, mmu_wdata and mmu_bytemode are held constant.
  - The counter decrements each cycle.
  - When counter = 0 on a read, capture mmu_rdata into the granted port's rdata register. Go to DONE.
- **DONE**
  - mmu_read = mmu_write = 0.
  - Assert the granted port's ack for exactly one cycle, then go to IDLE.
- Fetches are always word, read-only: mmu_bytemode = 0, we = 0.
- Stores do not update mem_rdata.
- The arbiter does no address decoding. Addresses pass unmodified, so SRAM and UART targets are handled identically.
- A req dropped mid-transaction is ignored: the transaction completes and ack is still issued.
- A req still high in the cycle after ack is treated as a new request.
- Reset values: state IDLE, last_grant IF, all command/data registers 0.
  - All outputs are 0: mmu_read, mmu_write, mmu_addr, mmu_wdata, mmu_bytemode, if_rdata, if_ack, mem_rdata, mem_ack.
  - stall is 0 when reqs are 0.
- rst asserted in any state returns to IDLE on the next edge and drops the MMU enables. No ack is issued for the aborted access.

## Timing
- Request first seen high in IDLE at edge 0:
  - ACCESS occupies cycles 1..WAIT_CYCLES.
  - DONE (ack high) is cycle WAIT_CYCLES+1.
  - IDLE is cycle WAIT_CYCLES+2.
- Latency from req to ack is WAIT_CYCLES+1 cycles. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- mmu_read/mmu_write are high for exactly WAIT_CYCLES consecutive cycles per access. The MMU command fields never change while they are high.
- Read data is sampled at the edge ending the last ACCESS cycle, and is visible on *_rdata in DONE.
- When both reqs are high at the same edge, only one port is served per pass. The loser keeps stall high until its own ack.

## Test plan
- Single fetch, WAIT_CYCLES=2, if_addr=0x80000010, mmu_rdata=0x12345678 -> mmu_read high for cycles 1–2, if_ack high in cycle 3, if_rdata=0x12345678, mmu_bytemode=0.
- Byte store: mem_we=1, mem_byte=1, mem_addr=0x80400004, mem_wdata=0xA5 -> mmu_write high for 2 cycles with mmu_bytemode=1 and mmu_wdata=0xA5; mem_ack in cycle 3; mem_rdata unchanged.
- Simultaneous if_req and mem_req held continuously after reset -> grant order MEM, IF, MEM, IF; stall high throughout; each ack is a single cycle.
- mem_req drops during ACCESS -> transaction completes, mem_ack still pulses, no second access started.
- rst asserted in the second ACCESS cycle -> next cycle mmu_read=0, no ack, state IDLE; a subsequent fetch completes normally.
- WAIT_CYCLES=1 sweep with alternating loads/stores to 0xBFD003F8 (UART) -> address passed unchanged; 3-cycle period per access.
